status_register: RTL
====================

// Module: status_register
// PURPOSE
//  Sits directly downstream of the ALU. Captures the ALU result into the adder hold register.
//  Maintains the 6502 processor status register P (N V - B D I Z C) from the ALU carry/overflow,
//  data-bus N/Z, explicit set/clear and PLP/RTI loads.
//  Feeds carry_in and enable_dec back to the ALU.
//  Drives P onto DB for PHP/BRK. Provides the delayed IRQ mask to the interrupt logic.
// PARAMETERS
//  P_RESET  8'h34  P value after reset: I=1, bit5=1, B=1, all others 0
// PORTS
//  clk          in   1  system clock; all state updates on rising edge
//  nrst         in   1  reset, asynchronous, active-low
//  alu_out      in   8  ALU result
//  alu_carry    in   1  ALU carry_out
//  alu_overflow in   1  ALU overflow
//  ld_hold      in   1  capture alu_out into hold register
//  hold_out     out  8  adder hold register (to SB/ADL drivers)
//  db_in        in   8  internal data bus
//  load_p_db    in   1  load N,V,D,I,Z,C from db_in[7,6,3,2,1,0] (PLP/RTI)
//  i_now        in   1  with load_p_db: I takes effect on the mask immediately (RTI)
//  upd_nz       in   1  N<=db_in[7]; Z<=(db_in==0)
//  upd_c        in   1  C<=alu_carry
//  upd_v        in   1  V<=alu_overflow
//  bit_nv       in   1  N<=db_in[7]; V<=db_in[6] (BIT)
//  set_c,clr_c,set_i,clr_i,set_d,clr_d,clr_v  in 1 each  explicit flag ops
//  instr_sync   in   1  one-cycle pulse at opcode fetch (instruction boundary)
//  brk_push     in   1  1: pushed B=1 (BRK/PHP); 0: pushed B=0 (IRQ/NMI)
//  p_out        out  8  {N,V,1,brk_push,D,I,Z,C} for DB during push
//  carry_to_alu out  1  = C (combinational from flag reg)
//  dec_to_alu   out  1  = D (combinational)
//  irq_mask     out  1  effective I seen by IRQ sampling
// BEHAVIOUR
//  Reset (nrst=0, async): hold_out=0; P=P_RESET; irq_mask=1. Reset mid-operation discards all pending updates.
//  Hold reg: ld_hold=1 -> hold_out=alu_out next edge; otherwise holds. Latency 1 cycle.
//  Only N,V,D,I,Z,C are stored; bits 5 and 4 exist only in p_out. bit5=1 constant; bit4=brk_push.
//  Per-flag priority on a single edge, highest first:
//   1. load_p_db
//   2. clr_x
//   3. set_x
//   4. bit_nv
//   5. upd_nz / upd_c / upd_v
//  Unasserted flags hold. Simultaneous set_x & clr_x: clear wins (bench flags it as a protocol warning).
//  Independent controls on different flags combine in one edge, e.g. upd_c+upd_v+upd_nz for ADC.
//  upd_nz uses db_in of the same cycle, not hold_out.
//  IRQ mask delay, via a shadow register i_eff:
//   - irq_mask=i_eff.
//   - On instr_sync, i_eff<=I as it stands after that edge's update (new I if set/clr_i coincides).
//   - load_p_db&i_now: i_eff<=db_in[2] same edge, ignoring instr_sync.
//   - Net effect: CLI/SEI/PLP change the mask at the next instruction boundary; RTI changes it at once.
//  carry_to_alu/dec_to_alu reflect the registered flags: 0-cycle combinational, 1-cycle after an update.
//  No stall/back-pressure. Every control is a single-cycle level sampled at the edge.
// STRUCTURE
//  cpu_pkg:
//   - flag index localparams FLAG_C=0,Z=1,I=2,D=3,B=4,U=5,V=6,N=7;
//   - P_RESET default;
//   - typedef struct packed flag_ctrl_t bundling the set/clr/upd strobes.
//  Sub-module alu_hold_reg: 8-bit load-enable register with async active-low reset.
//  Flag logic, shadow I and p_out mux are inline.
// TESTING
//  1. Reset at an arbitrary cycle with flags set -> p_out=8'h34 (brk_push=1), hold_out=0, irq_mask=1.
//  2. ADC decimal: set_d, then ld_hold with alu_out=8'h00, alu_carry=1, upd_c, then db_in=8'h00 upd_nz
//     -> C=1, Z=1, dec_to_alu=1, hold_out=00.
//  3. clr_i, then instr_sync two cycles later -> irq_mask stays 1 until the edge after instr_sync,
//     then 0. Repeat with set_i -> mask 1 only after the next instr_sync.
//  4. PLP db_in=8'hC3 -> P N,V,Z,C=1, D,I=0; irq_mask changes only at the next instr_sync.
//     RTI (i_now=1), db_in=8'h04 -> irq_mask=1 the same edge.
//  5. set_c&clr_c&upd_c (alu_carry=1) same cycle -> C=0.
//     load_p_db(db_in=0) with set_d -> D=0 (load wins).
//  6. BIT: db_in=8'h40 bit_nv+upd_nz -> N=0, V=1, Z=0.
//     Push with brk_push=0 -> p_out=8'h60 (V=1, bit5=1, B=0).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 status-register slice: flag bit positions,
// the reset value of P, and the bundles used for flag control and storage.
package cpu_pkg;

    // Bit positions of the flags inside P (N V - B D I Z C)
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // P after reset: I=1, bit5=1, B=1, everything else 0
    localparam logic [7:0] P_RESET_DEFAULT = 8'h34;

    // Per-edge flag strobes coming from the decoder
    typedef struct packed {
        logic load_p_db;
        logic i_now;
        logic upd_nz;
        logic upd_c;
        logic upd_v;
        logic bit_nv;
        logic set_c;
        logic clr_c;
        logic set_i;
        logic clr_i;
        logic set_d;
        logic clr_d;
        logic clr_v;
    } flag_ctrl_t;

    // The six flags that are physically stored (B and bit5 exist only on push)
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_hold_reg.sv
// Adder hold register: captures the ALU result when ld is asserted and
// presents it to the SB/ADL drivers one cycle later.
module alu_hold_reg (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ld,
    input  logic [7:0] d,
    output logic [7:0] q
);

    logic [7:0] hold_d;
    logic [7:0] hold_q;

    // Next value: load the new ALU result or keep the current one
    always_comb begin
        hold_d = hold_q;
        if (ld) hold_d = d;
    end

    // Hold register state, cleared by reset
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: state flops use <= so every flop samples pre-edge values; = here would create order-dependent races between blocks.
        if (!nrst) hold_q <= 8'h00;
        else       hold_q <= hold_d;
    end

    assign q = hold_q;

endmodule

// File: rtl/status_register.sv
// 6502 processor status register P plus the adder hold register.
// Flags are updated from ALU carry/overflow, data-bus N/Z, explicit set/clear
// strobes and PLP/RTI loads. A shadow copy of I (i_eff) delays mask changes
// to the next instruction boundary, except for RTI which applies at once.
module status_register
    import cpu_pkg::*;
#(
    parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       ld_hold,
    output logic [7:0] hold_out,
    input  logic [7:0] db_in,
    input  logic       load_p_db,
    input  logic       i_now,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_nv,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       clr_v,
    input  logic       instr_sync,
    input  logic       brk_push,
    output logic [7:0] p_out,
    output logic       carry_to_alu,
    output logic       dec_to_alu,
    output logic       irq_mask
);

    localparam flags_t FLAGS_RESET = '{
        n: P_RESET[FLAG_N], v: P_RESET[FLAG_V], d: P_RESET[FLAG_D],
        i: P_RESET[FLAG_I], z: P_RESET[FLAG_Z], c: P_RESET[FLAG_C]
    };

    flag_ctrl_t ctrl;
    flags_t     flags_d, flags_q;
    logic       i_eff_d, i_eff_q;

    assign ctrl = '{
        load_p_db: load_p_db, i_now: i_now, upd_nz: upd_nz, upd_c: upd_c,
        upd_v: upd_v, bit_nv: bit_nv, set_c: set_c, clr_c: clr_c,
        set_i: set_i, clr_i: clr_i, set_d: set_d, clr_d: clr_d, clr_v: clr_v
    };

    alu_hold_reg u_hold (
        .clk  (clk),
        .nrst (nrst),
        .ld   (ld_hold),
        .d    (alu_out),
        .q    (hold_out)
    );

    // Per-flag next state; load beats clear beats set beats BIT beats ALU/bus updates
    always_comb begin
        // NOTE: start from the held value so every path assigns flags_d; a missing default would infer a latch.
        flags_d = flags_q;

        if (ctrl.load_p_db || ctrl.bit_nv || ctrl.upd_nz) flags_d.n = db_in[FLAG_N];

        if      (ctrl.load_p_db) flags_d.v = db_in[FLAG_V];
        else if (ctrl.clr_v)     flags_d.v = 1'b0;
        else if (ctrl.bit_nv)    flags_d.v = db_in[FLAG_V];
        else if (ctrl.upd_v)     flags_d.v = alu_overflow;

        if      (ctrl.load_p_db) flags_d.d = db_in[FLAG_D];
        else if (ctrl.clr_d)     flags_d.d = 1'b0;
        else if (ctrl.set_d)     flags_d.d = 1'b1;

        if      (ctrl.load_p_db) flags_d.i = db_in[FLAG_I];
        else if (ctrl.clr_i)     flags_d.i = 1'b0;
        else if (ctrl.set_i)     flags_d.i = 1'b1;

        if      (ctrl.load_p_db) flags_d.z = db_in[FLAG_Z];
        else if (ctrl.upd_nz)    flags_d.z = (db_in == 8'h00);

        if      (ctrl.load_p_db) flags_d.c = db_in[FLAG_C];
        else if (ctrl.clr_c)     flags_d.c = 1'b0;
        else if (ctrl.set_c)     flags_d.c = 1'b1;
        else if (ctrl.upd_c)     flags_d.c = alu_carry;
    end

    // Shadow I: RTI applies immediately, otherwise the new I is adopted at the instruction boundary
    always_comb begin
        i_eff_d = i_eff_q;
        if (ctrl.load_p_db && ctrl.i_now) i_eff_d = db_in[FLAG_I];
        else if (instr_sync)              i_eff_d = flags_d.i;
    end

    // Flag and shadow-mask registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flags_q <= FLAGS_RESET;
            i_eff_q <= 1'b1;
        end else begin
            flags_q <= flags_d;
            i_eff_q <= i_eff_d;
        end
    end

    // Push image of P: bit5 always reads 1, B reflects the kind of push
    always_comb begin
        p_out         = 8'h00;
        p_out[FLAG_N] = flags_q.n;
        p_out[FLAG_V] = flags_q.v;
        p_out[FLAG_U] = 1'b1;
        p_out[FLAG_B] = brk_push;
        p_out[FLAG_D] = flags_q.d;
        p_out[FLAG_I] = flags_q.i;
        p_out[FLAG_Z] = flags_q.z;
        p_out[FLAG_C] = flags_q.c;
    end

    assign carry_to_alu = flags_q.c;
    assign dec_to_alu   = flags_q.d;
    assign irq_mask     = i_eff_q;

endmodule
